// File: rtl/palette_pkg.sv
// Shared definitions for the sprite palette RAM.
//   DEF_*            default parameter values for the palette blocks
//   rgb_t            packed {r,g,b} colour at the base 4-bit channel width
//   DEFAULT_PALETTE  reset contents of entries 0..4; entries 5 and up repeat entry 0
//   default_rgb()    reset colour for any palette index
package palette_pkg;

    localparam int DEF_IDX_W     = 4;
    localparam int DEF_CH_W      = 4;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_KEY_INDEX = 0;
    localparam int RGB_BASE_W    = 4;

    typedef struct packed {
        logic [RGB_BASE_W-1:0] r;
        logic [RGB_BASE_W-1:0] g;
        logic [RGB_BASE_W-1:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [5] = '{
        '{r: 4'hA, g: 4'hE, b: 4'hA},
        '{r: 4'h0, g: 4'h0, b: 4'hA},
        '{r: 4'hB, g: 4'h0, b: 4'hB},
        '{r: 4'hF, g: 4'hF, b: 4'hF},
        '{r: 4'hF, g: 4'h7, b: 4'h6}
    };

    function automatic rgb_t default_rgb(input int idx);
        rgb_t c;
        case (idx)
            1:       c = DEFAULT_PALETTE[1];
            2:       c = DEFAULT_PALETTE[2];
            3:       c = DEFAULT_PALETTE[3];
            4:       c = DEFAULT_PALETTE[4];
            default: c = DEFAULT_PALETTE[0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/palette_cycle_ctrl.sv
// Colour-cycling controller: per-frame rotation offset and lookup index remap.
//   i_clk, i_rst_n          clock, async active-low reset
//   i_cycle_en              colour cycling enable
//   i_cycle_lo, i_cycle_hi  inclusive index range being rotated
//   i_frame_tick            one-cycle pulse per video frame
//   i_rd_index              requested (pre-remap) lookup index
//   o_eff_index             index actually used to address the palette
module palette_cycle_ctrl
    import palette_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cycle_en,
    input  logic [IDX_W-1:0] i_cycle_lo,
    input  logic [IDX_W-1:0] i_cycle_hi,
    input  logic             i_frame_tick,
    input  logic [IDX_W-1:0] i_rd_index,
    output logic [IDX_W-1:0] o_eff_index
);

    logic [IDX_W-1:0] r_offset;

    // One extra bit so LEN = 2**IDX_W and lo + rel never wrap.
    logic [IDX_W:0] w_lo_x;
    logic [IDX_W:0] w_len;
    logic [IDX_W:0] w_off_inc;
    logic [IDX_W:0] w_rel;
    logic [IDX_W:0] w_rel_wrap;
    logic [IDX_W:0] w_sum;
    logic           w_active;
    logic           w_in_range;
    logic           w_unused_sum_msb;

    assign w_lo_x     = {1'b0, i_cycle_lo};
    assign w_len      = {1'b0, i_cycle_hi} - w_lo_x + (IDX_W+1)'(1);
    assign w_active   = i_cycle_en && (i_cycle_hi > i_cycle_lo);
    assign w_in_range = (i_rd_index >= i_cycle_lo) && (i_rd_index <= i_cycle_hi);
    assign w_off_inc  = {1'b0, r_offset} + (IDX_W+1)'(1);

    // rel < 2*LEN for in-range indices and offset < LEN, so one subtract suffices.
    assign w_rel      = {1'b0, i_rd_index} - w_lo_x + {1'b0, r_offset};
    assign w_rel_wrap = (w_rel >= w_len) ? (w_rel - w_len) : w_rel;
    assign w_sum      = w_lo_x + w_rel_wrap;
    assign w_unused_sum_msb = w_sum[IDX_W];

    assign o_eff_index = (w_active && w_in_range) ? w_sum[IDX_W-1:0] : i_rd_index;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_offset <= '0;
        end else if (!w_active) begin
            r_offset <= '0;
        end else if (i_frame_tick) begin
            // >= also recovers if the range shrank below the current offset.
            if (w_off_inc >= w_len) begin
                r_offset <= '0;
            end else begin
                r_offset <= w_off_inc[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_palette_ram.sv
// Banked sprite palette with registered lookup, write-first bypass and colour cycling.
//   Clk, Reset_n                       clock, async active-low reset
//   rd_valid, rd_bank, rd_index        lookup request
//   out_valid, red, green, blue        lookup result, one cycle after the request
//   transparent                        request index equalled KEY_INDEX
//   wr_en, wr_bank, wr_index, wr_color palette write, wr_color = {R,G,B}
//   cycle_en, cycle_lo, cycle_hi       colour cycling range control
//   frame_tick                         per-frame pulse advancing the cycle offset
module sprite_palette_ram
    import palette_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CH_W      = DEF_CH_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int KEY_INDEX = DEF_KEY_INDEX,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                rd_valid,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic [IDX_W-1:0]    rd_index,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [3*CH_W-1:0]   wr_color,
    input  logic                cycle_en,
    input  logic [IDX_W-1:0]    cycle_lo,
    input  logic [IDX_W-1:0]    cycle_hi,
    input  logic                frame_tick
);

    localparam int DEPTH = 1 << IDX_W;

    logic [3*CH_W-1:0] r_mem [NUM_BANKS][DEPTH];
    logic              r_out_valid;
    logic [3*CH_W-1:0] r_color;
    logic              r_transparent;

    logic [IDX_W-1:0]  w_eff_index;
    logic              w_bypass;
    logic [3*CH_W-1:0] w_rd_color;

    // Reset colour widened to CH_W by shifting the 4-bit value into the MSBs.
    function automatic logic [3*CH_W-1:0] scaled_default(input int idx);
        rgb_t c;
        logic [CH_W-1:0] r, g, b;
        c = default_rgb(idx);
        r = CH_W'(c.r) << (CH_W - RGB_BASE_W);
        g = CH_W'(c.g) << (CH_W - RGB_BASE_W);
        b = CH_W'(c.b) << (CH_W - RGB_BASE_W);
        return {r, g, b};
    endfunction

    palette_cycle_ctrl #(
        .IDX_W (IDX_W)
    ) u_cycle_ctrl (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_cycle_en   (cycle_en),
        .i_cycle_lo   (cycle_lo),
        .i_cycle_hi   (cycle_hi),
        .i_frame_tick (frame_tick),
        .i_rd_index   (rd_index),
        .o_eff_index  (w_eff_index)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[b][i] <= scaled_default(i);
                end
            end
        end else if (wr_en) begin
            r_mem[wr_bank][wr_index] <= wr_color;
        end
    end

    // Write-first: a read hitting the entry being written sees the new colour.
    assign w_bypass   = wr_en && (wr_bank == rd_bank) && (wr_index == w_eff_index);
    assign w_rd_color = w_bypass ? wr_color : r_mem[rd_bank][w_eff_index];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid   <= 1'b0;
            r_color       <= '0;
            r_transparent <= 1'b0;
        end else begin
            r_out_valid <= rd_valid;
            if (rd_valid) begin
                r_color       <= w_rd_color;
                r_transparent <= (rd_index == IDX_W'(KEY_INDEX));
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign red         = r_color[3*CH_W-1 -: CH_W];
    assign green       = r_color[2*CH_W-1 -: CH_W];
    assign blue        = r_color[CH_W-1:0];
    assign transparent = r_transparent;

endmodule

// File: tb/tb_sprite_palette_ram.sv
module tb_sprite_palette_ram;

    logic        Clk;
    logic        Reset_n;
    logic        rd_valid;
    logic [1:0]  rd_bank;
    logic [3:0]  rd_index;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_color;
    logic        cycle_en;
    logic [3:0]  cycle_lo, cycle_hi;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    sprite_palette_ram dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .rd_index    (rd_index),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_color    (wr_color),
        .cycle_en    (cycle_en),
        .cycle_lo    (cycle_lo),
        .cycle_hi    (cycle_hi),
        .frame_tick  (frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] bank, input logic [3:0] idx,
                          input logic [11:0] exp_rgb, input logic exp_tr);
        rd_valid = 1'b1;
        rd_bank  = bank;
        rd_index = idx;
        tick();
        rd_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
        chk({tag, "_tr"}, 32'(transparent), 32'(exp_tr));
    endtask

    initial begin
        Reset_n = 1'b0; rd_valid = 1'b0; rd_bank = '0; rd_index = '0;
        wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_color = '0;
        cycle_en = 1'b0; cycle_lo = '0; cycle_hi = '0; frame_tick = 1'b0;

        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_tr", 32'(transparent), 32'd0);
        Reset_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // default palette lookups and transparency key
        rd_chk("b2i4", 2'd2, 4'd4, 12'hF76, 1'b0);
        rd_chk("b2i0", 2'd2, 4'd0, 12'hAEA, 1'b1);
        tick();
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_rgb", 32'({red, green, blue}), 32'hAEA);
        chk("hold_tr", 32'(transparent), 32'd1);

        // plain write then reads
        wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd3; wr_color = 12'h123;
        tick();
        wr_en = 1'b0;
        rd_chk("b1i3_wr", 2'd1, 4'd3, 12'h123, 1'b0);
        rd_chk("b0i3_def", 2'd0, 4'd3, 12'hFFF, 1'b0);
        rd_chk("b1i2_def", 2'd1, 4'd2, 12'hB0B, 1'b0);

        // same-cycle write/read bypass
        wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd7; wr_color = 12'h555;
        rd_chk("bypass", 2'd0, 4'd7, 12'h555, 1'b0);
        wr_en = 1'b0;
        rd_chk("b0i7_stored", 2'd0, 4'd7, 12'h555, 1'b0);

        // colour cycling lo=1 hi=4 (LEN 4)
        cycle_en = 1'b1; cycle_lo = 4'd1; cycle_hi = 4'd4;
        ftick(); ftick(); ftick();
        rd_chk("cyc3_i1", 2'd0, 4'd1, 12'hF76, 1'b0);
        rd_chk("cyc3_i4", 2'd0, 4'd4, 12'hFFF, 1'b0);
        rd_chk("cyc3_i0", 2'd0, 4'd0, 12'hAEA, 1'b1);
        ftick();
        rd_chk("cyc0_i1", 2'd0, 4'd1, 12'h00A, 1'b0);

        // tick and read together use the old offset
        frame_tick = 1'b1;
        rd_chk("tick_rd_old", 2'd0, 4'd1, 12'h00A, 1'b0);
        frame_tick = 1'b0;
        rd_chk("cyc1_i1", 2'd0, 4'd1, 12'hB0B, 1'b0);
        ftick();
        rd_chk("cyc2_i2", 2'd0, 4'd2, 12'hF76, 1'b0);

        // disable clears offset
        cycle_en = 1'b0;
        rd_chk("dis_i2", 2'd0, 4'd2, 12'hB0B, 1'b0);
        cycle_en = 1'b1;
        rd_chk("reen_i1", 2'd0, 4'd1, 12'h00A, 1'b0);

        // hi == lo is an inactive range
        cycle_lo = 4'd4; cycle_hi = 4'd4;
        ftick();
        rd_chk("inact_i4", 2'd0, 4'd4, 12'hF76, 1'b0);

        // reset in flight
        cycle_lo = 4'd1; cycle_hi = 4'd4;
        ftick();
        rd_chk("pre_rst_i1", 2'd0, 4'd1, 12'hB0B, 1'b0);
        rd_valid = 1'b1; rd_bank = 2'd1; rd_index = 4'd3;
        tick();
        chk("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_rgb", 32'({red, green, blue}), 32'd0);
        chk("async_tr", 32'(transparent), 32'd0);
        wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd5; wr_color = 12'h999;
        tick();
        chk("in_rst_valid", 32'(out_valid), 32'd0);
        wr_en = 1'b0; rd_valid = 1'b0;
        Reset_n = 1'b1;
        tick();
        chk("drop_valid", 32'(out_valid), 32'd0);
        rd_chk("rst_b1i3", 2'd1, 4'd3, 12'hFFF, 1'b0);
        rd_chk("rst_b0i7", 2'd0, 4'd7, 12'hAEA, 1'b0);
        rd_chk("rst_b0i5", 2'd0, 4'd5, 12'hAEA, 1'b0);
        rd_chk("rst_b1i1", 2'd1, 4'd1, 12'h00A, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
